sevenseg_scan_n: RTL and testbench
==================================

Name: sevenseg_scan_n

Overview:
- Parametrised N-digit multiplexed seven-segment driver.
- Double-buffered load with frame-synchronous update, so the display never tears.
- Full hex decode (0-F), per-digit decimal point and blanking, runtime leading-zero suppression.
- Sits between the systolic array result/status logic and the board's common-anode display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (any value 2..8, need not be a power of two).
- DIV_W, 16, prescaler width; each digit dwells 2^DIV_W clocks.
- BRIGHT_W, 4, brightness field width (used only with SSEG_DIM_EN).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  capture request for digits_in/dp_in/blank_in into the shadow buffer.
- digits_in  in  4*N_DIGITS  nibble i = digit i (digit 0 = rightmost).
- dp_in  in  N_DIGITS  1 = light the decimal point of digit i.
- blank_in  in  N_DIGITS  1 = force digit i dark (segments and dp).
- lz_blank  in  1  1 = suppress leading zeros.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  N_DIGITS  digit enables, active-low, one-hot-zero.
- frame_done  out  1  single-cycle pulse at end of each full scan.
- update_pending  out  1  shadow holds data not yet displayed.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - tick_cnt=0, idx=0, shadow/active regs all 0, update_pending=0, frame_done=0.
  - seg=7'h7F, dp=1, an=all ones.
- Prescaler: tick_cnt (DIV_W bits) increments every clock; tick = (tick_cnt == all ones).
- Digit index advance:
  - On tick, idx advances; idx==N_DIGITS-1 wraps to 0. Never reaches values >= N_DIGITS.
  - frame_done=1 for exactly one cycle when tick && idx==N_DIGITS-1.
- Load:
  - load=1 captures the inputs into shadow and sets update_pending. Back-to-back loads overwrite; the last one wins.
  - On a frame_done cycle with pending set: active <= shadow, update_pending cleared.
  - load coincident with frame_done: active <= old shadow, shadow <= new inputs, update_pending remains 1.
  - Pending data is displayed from the first digit of the next frame. Worst-case load-to-display latency is N_DIGITS*2^DIV_W + 1 clocks.
- Decode:
  - Nibble 0-F uses the standard active-low hex patterns (0=7'b1000000, A=7'b0001000, F=7'b0001110).
  - blank -> 7'h7F and dp=1.
- Leading-zero suppression (lz_blank=1):
  - Scanning from digit N_DIGITS-1 downward, digits whose nibble is 0 are blanked until the first non-zero digit.
  - Digit 0 is never suppressed.
  - A suppressed digit with dp_in set still shows its dp.
  - Suppression is evaluated on the active buffer only.
- Output registers: seg/dp/an are registered and change one clock after idx changes.
- an[i]=0 only when the registered index == i.
- blank_in affects segments/dp only; an still strobes, which keeps scan timing uniform.
- Reset mid-scan returns to idx=0 and discards both buffers.

Optional Feature:
- Macro: SSEG_DIM_EN.
- Defined:
  - Adds input brightness[BRIGHT_W-1:0].
  - an for the current digit is driven low only while tick_cnt[DIV_W-1 -: BRIGHT_W] < brightness; otherwise all ones. seg/dp are unchanged.
  - brightness=0 gives a dark display; the maximum value gives duty (2^BRIGHT_W-1)/2^BRIGHT_W.
  - Requires DIV_W >= BRIGHT_W.
- Undefined: no brightness port; full duty; an behaves as specified above.

Decomposition:
- Package sevenseg_pkg:
  - SEG_BLANK (7'h7F), SEG_DASH (7'b0111111).
  - 16-entry hex pattern constants.
  - Digit nibble width constant (4).
- Sub-module sevenseg_hex_decode: combinational nibble+blank -> 7-bit pattern, reused by other display blocks.
- Scan counter, buffers and LZ logic stay in the top.

Test Plan:
- Reset/scan, DIV_W=2, N_DIGITS=4, no load:
  - After reset_n release, an steps 1110 -> 1101 -> 1011 -> 0111 every 4 clocks.
  - seg=7'b1000000 on every digit.
  - frame_done pulses once every 16 clocks.
- Non-power-of-two, N_DIGITS=3:
  - idx wraps 2 -> 0.
  - an never all zeros and never shows a fourth pattern.
  - frame_done period is 12 clocks.
- Load mid-frame:
  - Load digits_in=16'hA5F0 while idx=1; update_pending=1.
  - Old data continues until frame_done.
  - The next frame shows 0, F, 5, A on digits 0..3; update_pending then falls.
- Load coincident with frame_done:
  - Earlier shadow 16'h1234 reaches active; new 16'h5678 stays pending and appears one frame later.
- Leading-zero suppression:
  - digits 16'h0070, dp_in=4'b1000, lz_blank=1.
  - Digit 3 shows dp only (seg 7'h7F, dp=0); digit 2 blank; digit 1 shows 7; digit 0 shows 0.
- Async reset mid-frame:
  - Assert reset_n low at idx=2 with update_pending=1.
  - Outputs immediately go to seg=7'h7F, dp=1, an=1111, update_pending=0.
- SSEG_DIM_EN, DIV_W=4, BRIGHT_W=2, brightness=1: each digit's an is low for 4 of its 16 dwell clocks.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants: active-low {g,f,e,d,c,b,a} glyphs for hex digits,
// blank and dash patterns, and the digit nibble width.
package sevenseg_pkg;

    localparam int NIB_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] HEX_PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph, with a blank override.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    input  logic             blank,
    output logic [6:0]       seg
);

    assign seg = blank ? SEG_BLANK : HEX_PAT[nibble];

endmodule

// File: rtl/sevenseg_scan_n.sv
// N-digit multiplexed common-anode seven-segment driver with a shadow/active buffer
// pair swapped at frame end. Optional PWM dimming of the anodes with `SSEG_DIM_EN.
module sevenseg_scan_n
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV_W    = 16,
    parameter int BRIGHT_W = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [NIB_W*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]       dp_in,
    input  logic [N_DIGITS-1:0]       blank_in,
    input  logic                      lz_blank,
`ifdef SSEG_DIM_EN
    input  logic [BRIGHT_W-1:0]       brightness,
`endif
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [N_DIGITS-1:0]       an,
    output logic                      frame_done,
    output logic                      update_pending
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    typedef struct packed {
        logic [N_DIGITS-1:0][NIB_W-1:0] digits;
        logic [N_DIGITS-1:0]            dp;
        logic [N_DIGITS-1:0]            blank;
    } dbuf_t;

    logic [DIV_W-1:0]    tick_cnt;
    logic [IDX_W-1:0]    idx;
    logic                tick;
    dbuf_t               shadow, active;
    logic [N_DIGITS-1:0] lz_sup;
    logic                zrun;
    logic                cur_blank;
    logic [6:0]          dec_seg;
    logic [N_DIGITS-1:0] an_nxt;

    assign tick       = &tick_cnt;
    assign frame_done = tick && (idx == LAST_IDX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt       <= '0;
            idx            <= '0;
            shadow         <= '0;
            active         <= '0;
            update_pending <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            // Swap samples the old shadow, so a coincident load stays pending a frame.
            if (frame_done && update_pending)
                active <= shadow;
            if (load) begin
                shadow         <= '{digits: digits_in, dp: dp_in, blank: blank_in};
                update_pending <= 1'b1;
            end else if (frame_done) begin
                update_pending <= 1'b0;
            end
        end
    end

    // Zero run from the top digit down; digit 0 always shows.
    always_comb begin
        zrun   = lz_blank;
        lz_sup = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            zrun      = zrun && (active.digits[i] == '0);
            lz_sup[i] = zrun;
        end
    end

    assign cur_blank = active.blank[idx];

    sevenseg_hex_decode u_dec (
        .nibble (active.digits[idx]),
        .blank  (cur_blank | lz_sup[idx]),
        .seg    (dec_seg)
    );

    always_comb begin
        an_nxt = '1;
        for (int i = 0; i < N_DIGITS; i++)
            an_nxt[i] = (idx != IDX_W'(i));
`ifdef SSEG_DIM_EN
        if (tick_cnt[DIV_W-1 -: BRIGHT_W] >= brightness)
            an_nxt = '1;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= dec_seg;
            dp  <= ~(active.dp[idx] & ~cur_blank);
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Bench for sevenseg_scan_n: 4-digit and 3-digit instances with a 4-clock dwell,
// a cycle-count based display model, directed scenarios and a random load phase.
module tb_sevenseg_scan_n;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_blank;
    logic [1:0]  brightness = 2'd3;

    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    logic        update_pending;

    logic [6:0]  seg3;
    logic        dp3;
    logic [2:0]  an3;
    logic        fd3;
    logic        pend3;

    always #5 clock = ~clock;

    sevenseg_scan_n #(.N_DIGITS(4), .DIV_W(2), .BRIGHT_W(2)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .load           (load),
        .digits_in      (digits),
        .dp_in          (dp_in),
        .blank_in       (blank_in),
        .lz_blank       (lz_blank),
`ifdef SSEG_DIM_EN
        .brightness     (brightness),
`endif
        .seg            (seg),
        .dp             (dp),
        .an             (an),
        .frame_done     (frame_done),
        .update_pending (update_pending)
    );

    sevenseg_scan_n #(.N_DIGITS(3), .DIV_W(2), .BRIGHT_W(2)) dut3 (
        .clock          (clock),
        .reset_n        (reset_n),
        .load           (load),
        .digits_in      (digits[11:0]),
        .dp_in          (dp_in[2:0]),
        .blank_in       (blank_in[2:0]),
        .lz_blank       (lz_blank),
`ifdef SSEG_DIM_EN
        .brightness     (brightness),
`endif
        .seg            (seg3),
        .dp             (dp3),
        .an             (an3),
        .frame_done     (fd3),
        .update_pending (pend3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Model: m_cnt counts clock edges since reset release; each digit dwells 4 clocks.
    int          m_cnt;
    logic [15:0] sh_d, ac_d;
    logic [3:0]  sh_p, ac_p, sh_b, ac_b;
    bit          m_pend, m_pend3;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    int          dg, hi;
    bit          fd4, f3;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0; sh_d = 0; ac_d = 0; sh_p = 0; ac_p = 0; sh_b = 0; ac_b = 0;
            m_pend = 0; m_pend3 = 0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
        end else begin
            dg = (m_cnt % 16) / 4;
            hi = 0;
            for (int k = 0; k < 4; k++)
                if (ac_d[k*4 +: 4] != 4'h0) hi = k;
            e_seg = (ac_b[dg] || (lz_blank && dg > hi)) ? 7'h7F : glyph(ac_d[dg*4 +: 4]);
            e_dp  = !(ac_p[dg] && !ac_b[dg]);
            e_an  = ~(4'(1) << dg);
`ifdef SSEG_DIM_EN
            if ((m_cnt % 4) >= int'(brightness)) e_an = 4'hF;
`endif
            fd4 = (m_cnt % 16) == 15;
            f3  = (m_cnt % 12) == 11;
            if (fd4 && m_pend) begin ac_d = sh_d; ac_p = sh_p; ac_b = sh_b; end
            if (load) begin
                sh_d = digits; sh_p = dp_in; sh_b = blank_in; m_pend = 1; m_pend3 = 1;
            end else begin
                if (fd4) m_pend = 0;
                if (f3) m_pend3 = 0;
            end
            m_cnt++;
        end
    end

    function automatic logic [2:0] exp_an3(input int c);
        logic [2:0] r;
        if (c == 0) return 3'b111;
        r = ~(3'(1) << (((c - 1) % 12) / 4));
`ifdef SSEG_DIM_EN
        if (((c - 1) % 4) >= int'(brightness)) r = 3'b111;
`endif
        return r;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("seg", {25'd0, seg}, {25'd0, e_seg});
            chk("dp", {31'd0, dp}, {31'd0, e_dp});
            chk("an", {28'd0, an}, {28'd0, e_an});
            chk("pending", {31'd0, update_pending}, {31'd0, m_pend});
            chk("frame_done", {31'd0, frame_done}, (m_cnt % 16) == 15);
            chk("an3", {29'd0, an3}, {29'd0, exp_an3(m_cnt)});
            chk("frame_done3", {31'd0, fd3}, (m_cnt % 12) == 11);
            chk("pending3", {31'd0, pend3}, {31'd0, m_pend3});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_pos(input int p);
        int g = 0;
        @(negedge clock);
        while ((m_cnt % 16) != p && g < 64) begin
            @(negedge clock);
            g++;
        end
        if (g >= 64) chk("wait_pos_timeout", 32'(g), 32'd0);
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        load = 1'b1; digits = d; dp_in = p; blank_in = b;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic pin(input string nm, input logic [3:0] x_an, input logic [6:0] x_seg, input logic x_dp);
        chk({nm, "_an"}, {28'd0, an}, {28'd0, x_an});
        chk({nm, "_seg"}, {25'd0, seg}, {25'd0, x_seg});
        chk({nm, "_dp"}, {31'd0, dp}, {31'd0, x_dp});
    endtask

    initial begin
        int nfd;
        reset_n = 1'b0; load = 1'b0; digits = '0; dp_in = '0; blank_in = '0; lz_blank = 1'b0;
        tick(3);
        chk_en = 1;
        pin("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset_pending", {31'd0, update_pending}, 32'd0);
        reset_n = 1'b1;

        // First digit after release, then the step to digit 1.
        tick(1);
        pin("scan0", 4'b1110, 7'h40, 1'b1);
        tick(4);
        pin("scan1", 4'b1101, 7'h40, 1'b1);
        nfd = 0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (frame_done) nfd++;
        end
        chk("fd_per_32", 32'(nfd), 32'd2);

        // Load mid-frame at digit 1.
        wait_pos(5);
        pulse_load(16'hA5F0, 4'h0, 4'h0);
        chk("load_pending", {31'd0, update_pending}, 32'd1);
        wait_pos(15);
        tick(2);
        pin("a5f0_d0", 4'b1110, 7'h40, 1'b1);
        chk("a5f0_pending_clr", {31'd0, update_pending}, 32'd0);
        tick(4); pin("a5f0_d1", 4'b1101, 7'h0E, 1'b1);
        tick(4); pin("a5f0_d2", 4'b1011, 7'h12, 1'b1);
        tick(4); pin("a5f0_d3", 4'b0111, 7'h08, 1'b1);

        // Load coincident with frame_done.
        wait_pos(6);
        pulse_load(16'h1234, 4'h0, 4'h0);
        wait_pos(15);
        pulse_load(16'h5678, 4'h0, 4'h0);
        tick(1);
        pin("coin_1234", 4'b1110, 7'h19, 1'b1);
        chk("coin_pending", {31'd0, update_pending}, 32'd1);
        wait_pos(15);
        tick(2);
        pin("coin_5678", 4'b1110, 7'h00, 1'b1);
        chk("coin_pending_clr", {31'd0, update_pending}, 32'd0);

        // Leading-zero suppression.
        wait_pos(4);
        lz_blank = 1'b1;
        pulse_load(16'h0070, 4'b1000, 4'h0);
        wait_pos(15);
        tick(2);
        pin("lz_d0", 4'b1110, 7'h40, 1'b1);
        tick(4); pin("lz_d1", 4'b1101, 7'h78, 1'b1);
        tick(4); pin("lz_d2", 4'b1011, 7'h7F, 1'b1);
        tick(4); pin("lz_d3", 4'b0111, 7'h7F, 1'b0);

        // Async reset at digit 2 with an update pending.
        wait_pos(3);
        pulse_load(16'h9999, 4'hF, 4'h0);
        wait_pos(9);
        chk("pre_rst_pending", {31'd0, update_pending}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        pin("async_rst", 4'hF, 7'h7F, 1'b1);
        chk("async_rst_pending", {31'd0, update_pending}, 32'd0);
        tick(2);
        reset_n = 1'b1;

        // Random loads, flags and suppression.
        for (int i = 0; i < 800; i++) begin
            tick(1);
            load     = ($urandom % 6) == 0;
            digits   = 16'($urandom);
            if ($urandom % 3 == 0) digits[15:8] = 8'h00;
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom & $urandom & $urandom);
            if ($urandom % 16 == 0) lz_blank = ~lz_blank;
        end
        load = 1'b0;
        tick(40);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
